// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS32 host run controller.
package mips_ctrl_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_DUMP    = 6;
  localparam int DEF_TIMEOUT = 1024;

  // Opcode of the core's halt instruction, handy when building test programs.
  localparam logic [5:0] OP_HLT = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DUMP,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/mips_watchdog.sv
// RUN-cycle counter: clears on run start, counts while enabled, saturates,
// and flags when the watchdog limit has been reached.
module mips_watchdog #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/mips_run_ctrl.sv
// Host-facing run controller: loads program memory, starts the core, waits
// for HALTED under a watchdog, then streams out the low architectural registers.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DUMP_REGS   = DEF_DUMP,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles,
  output logic                 core_init,
  output logic                 core_run,
  input  logic                 core_halted,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [DATA_W-1:0]    dump_data
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(DUMP_REGS - 1);

  state_e               state_q, state_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic                 ld_fire;
  logic                 start_ok;
  logic                 wd_en;
  logic                 wd_tc;

  // Loads and starts are only accepted while the core is parked.
  assign ld_ready = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign ld_fire  = ld_valid && ld_ready;
  assign start_ok = start && ld_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        idx_d = '0;
        // Halt takes priority over an expiring watchdog in the same cycle.
        if (core_halted) begin
          state_d = ST_DUMP;
        end else if (wd_tc) begin
          state_d = ST_ERR;
        end else begin
          wd_en = 1'b1;
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mem_we_q <= ld_fire;
      if (ld_fire) begin
        mem_addr_q  <= ld_addr;
        mem_wdata_q <= ld_data;
      end
    end
  end

  mips_watchdog #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (start_ok),
    .en_i  (wd_en),
    .cnt_o (cycles),
    .tc_o  (wd_tc)
  );

  assign busy       = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign done       = (state_q == ST_DONE);
  assign timeout    = (state_q == ST_ERR);
  assign core_init  = (state_q == ST_INIT);
  assign core_run   = (state_q == ST_RUN);
  assign dump_valid = (state_q == ST_DUMP);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rf_raddr   = idx_q;
  assign dump_idx   = idx_q;
  assign dump_data  = dump_valid ? rf_rdata : '0;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a behavioural one-instruction-per-cycle core model
// serves memory and registers; results are checked against arithmetic expectations.
`timescale 1ns/1ps
module tb_mips_run_ctrl;
  import mips_ctrl_pkg::*;

  localparam int ADDR_W = 10, DATA_W = 32, DUMP_REGS = 6, TIMEOUT_CYC = 64, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ld_valid = 1'b0, start = 1'b0, dump_ready = 1'b1;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic ld_ready, busy, done, timeout, core_init, core_run, core_halted, mem_we, dump_valid;
  logic [CNT_W-1:0] cycles;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, rf_rdata, dump_data;
  logic [4:0] rf_raddr, dump_idx;

  always #5 clk = ~clk;

  mips_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMP_REGS(DUMP_REGS),
                  .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles), .core_init(core_init), .core_run(core_run),
    .core_halted(core_halted), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data));

  // ---------------- behavioural core: memory, register file, interpreter
  logic [31:0] imem [0:1023] = '{default: 32'h0};
  logic [31:0] regs [0:31]   = '{default: 32'h0};
  logic [ADDR_W-1:0] pc = '0;
  logic halted = 1'b0;
  logic [31:0] ir;
  assign ir          = imem[pc];
  assign core_halted = halted;
  assign rf_rdata    = regs[rf_raddr];

  always @(posedge clk) begin
    if (mem_we) imem[mem_addr] <= mem_wdata;
    if (core_init) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (core_run && !halted) begin
      pc <= pc + 1'b1;
      case (ir[31:26])
        6'h00: if (ir[15:11] != 5'd0) regs[ir[15:11]] <= regs[ir[25:21]] + regs[ir[20:16]];
        6'h03: if (ir[15:11] != 5'd0) regs[ir[15:11]] <= regs[ir[25:21]] | regs[ir[20:16]];
        6'h0a: if (ir[20:16] != 5'd0) regs[ir[20:16]] <= regs[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
        OP_HLT: halted <= 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- monitors (sampled on the falling edge)
  typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct packed { logic [4:0] i; logic [DATA_W-1:0] d; } dp_t;
  wr_t wr_log[$];
  dp_t dump_log[$];
  int init_cnt = 0, run_cnt = 0, init_err = 0, we_busy = 0, we_init = 0, rdy_busy = 0, stab_err = 0;
  logic prev_stall = 1'b0;
  logic [4:0] prev_idx = '0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (mem_we) wr_log.push_back(wr_t'{mem_addr, mem_wdata});
    if (dump_valid && dump_ready) dump_log.push_back(dp_t'{dump_idx, dump_data});
    if (core_init) init_cnt <= init_cnt + 1;
    if (core_run) run_cnt <= run_cnt + 1;
    if (core_init && core_run) init_err <= init_err + 1;
    if (mem_we && (core_run || dump_valid)) we_busy <= we_busy + 1;
    if (mem_we && core_init) we_init <= we_init + 1;
    if (ld_ready && busy) rdy_busy <= rdy_busy + 1;
    if (rst_n && prev_stall && (!dump_valid || dump_idx != prev_idx || dump_data != prev_data))
      stab_err <= stab_err + 1;
    prev_stall <= dump_valid && !dump_ready;
    prev_idx   <= dump_idx;
    prev_data  <= dump_data;
  end

  // ---------------- checking helpers
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cycles"}, cycles, 0);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
  endtask

  // Load vectors: input {addr,data}; expected mem write carries the same pair.
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } ld_vec_t;
  ld_vec_t vecs[$];
  logic [31:0] sum_prog [0:8];

  function automatic logic [31:0] addi(input logic [4:0] rt, input logic [15:0] imm);
    return {6'h0a, 5'd0, rt, imm};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 11'd0};
  endfunction

  task automatic set_prog(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [31:0] w [0:8];
    w = '{addi(1, a), addi(2, b), addi(3, c), 32'h0ce77800, 32'h0ce77800,
          add(4, 1, 2), 32'h0ce77800, add(5, 4, 3), {OP_HLT, 26'd0}};
    for (int k = 0; k < 9; k++) vecs.push_back('{ADDR_W'(k), w[k]});
  endtask

  task automatic set_nops();
    for (int k = 0; k < 9; k++) vecs.push_back('{ADDR_W'(k), 32'h0ce77800});
  endtask

  task automatic load_vecs();
    int base;
    base = wr_log.size();
    chk("ld_ready_before_load", ld_ready, 1);
    foreach (vecs[k]) begin
      ld_valid = 1'b1;
      ld_addr  = vecs[k].addr;
      ld_data  = vecs[k].data;
      tick();
    end
    ld_valid = 1'b0;
    tick();
    chk("wr_count", wr_log.size() - base, vecs.size());
    for (int k = 0; k < vecs.size() && base + k < wr_log.size(); k++) begin
      chk($sformatf("wr%0d_addr", k), wr_log[base+k].a, vecs[k].addr);
      chk($sformatf("wr%0d_data", k), wr_log[base+k].d, vecs[k].data);
    end
    vecs.delete();
  endtask

  task automatic chk_dump(input int base, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] e [0:5];
    e = '{32'd0, a, b, c, a + b, a + b + c};
    chk("dump_count", dump_log.size() - base, DUMP_REGS);
    for (int k = 0; k < DUMP_REGS && base + k < dump_log.size(); k++) begin
      chk($sformatf("dump%0d_idx", k), dump_log[base+k].i, k);
      chk($sformatf("dump%0d_data", k), dump_log[base+k].d, e[k]);
    end
  endtask

  // mode 0: ready always; 1: hold 3 cycles at idx 2 and 4; 2: random ready
  task automatic run_prog(input int mode, input bit noise, input bit do_start, output int stalls);
    int h2, h4;
    bit fin;
    h2 = 0; h4 = 0; fin = 1'b0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("start_clears_done", done, 0);
    chk("start_clears_cycles", cycles, 0);
    chk("busy_in_init", busy, 1);
    for (int t = 0; t < 400 && !fin; t++) begin
      case (mode)
        0: dump_ready = 1'b1;
        1: begin
          if (dump_valid && dump_idx == 5'd2 && h2 < 3) begin dump_ready = 1'b0; h2++; end
          else if (dump_valid && dump_idx == 5'd4 && h4 < 3) begin dump_ready = 1'b0; h4++; end
          else dump_ready = 1'b1;
        end
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise && busy) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_addr  = ADDR_W'($urandom);
        ld_data  = $urandom;
        start    = 1'($urandom_range(0, 1));
      end else begin
        ld_valid = 1'b0;
        start    = 1'b0;
      end
      if (done || timeout) fin = 1'b1;
      else tick();
    end
    ld_valid = 1'b0;
    start = 1'b0;
    dump_ready = 1'b1;
    stalls = h2 + h4;
    chk("run_terminates", fin, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound exceeded");
    $fatal(1);
  end

  initial begin
    int db, wb, ib, rb, rb1, st, sb;
    logic [CNT_W-1:0] cyc1;
    logic [15:0] ra, rbv, rc;

    sum_prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    // Reset values
    tick(); tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Test 1: sum program
    for (int k = 0; k < 9; k++) vecs.push_back('{ADDR_W'(k), sum_prog[k]});
    load_vecs();
    db = dump_log.size(); ib = init_cnt; rb = run_cnt;
    run_prog(0, 1'b0, 1'b1, st);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_timeout", timeout, 0);
    chk("t1_init_pulses", init_cnt - ib, 1);
    chk("t1_init_no_run", init_err, 0);
    chk_dump(db, 10, 20, 25);
    cyc1 = cycles;
    rb1  = run_cnt - rb;

    // Test 2 + 4a: watchdog with host noise during RUN
    set_nops();
    load_vecs();
    db = dump_log.size(); rb = run_cnt; wb = we_busy;
    run_prog(0, 1'b1, 1'b1, st);
    chk("t2_timeout", timeout, 1);
    chk("t2_done", done, 0);
    chk("t2_cycles", cycles, TIMEOUT_CYC - 1);
    chk("t2_run_cycles", run_cnt - rb, TIMEOUT_CYC);
    chk("t2_no_dump", dump_log.size() - db, 0);
    chk("t4_no_write_busy", we_busy - wb, 0);
    chk("t4_no_ready_busy", rdy_busy, 0);

    // Test 3: backpressure at idx 2 and 4
    set_prog(10, 20, 25);
    load_vecs();
    db = dump_log.size(); sb = stab_err;
    run_prog(1, 1'b0, 1'b1, st);
    chk("t3_done", done, 1);
    chk("t3_stall_cycles", st, 6);
    chk("t3_stable_while_stalled", stab_err - sb, 0);
    chk_dump(db, 10, 20, 25);

    // Test 4b: load + start together from DONE; R3 immediate changed to 30
    db = dump_log.size(); wb = we_init;
    ld_valid = 1'b1; ld_addr = 10'd2; ld_data = addi(3, 30); start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    run_prog(0, 1'b0, 1'b0, st);
    chk("t4b_write_in_init", we_init - wb, 1);
    chk("t4b_done", done, 1);
    chk_dump(db, 10, 20, 30);

    // Test 5: reset mid-RUN
    set_nops();
    load_vecs();
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    chk("t5_in_run", core_run, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_run");
    tick(); rst_n = 1'b1; tick();

    // Test 5: reset mid-DUMP at idx 3
    for (int k = 0; k < 9; k++) vecs.push_back('{ADDR_W'(k), sum_prog[k]});
    load_vecs();
    start = 1'b1; tick(); start = 1'b0;
    dump_ready = 1'b1;
    for (int t = 0; t < 200 && !(dump_valid && dump_idx == 5'd3); t++) tick();
    chk("t5_reached_idx3", {dump_valid, dump_idx}, {1'b1, 5'd3});
    rst_n = 1'b0;
    #1;
    chk_reset("rst_dump");
    tick(); rst_n = 1'b1; tick();
    for (int k = 0; k < 9; k++) vecs.push_back('{ADDR_W'(k), sum_prog[k]});
    load_vecs();
    db = dump_log.size();
    run_prog(0, 1'b0, 1'b1, st);
    chk("t5_done", done, 1);
    chk_dump(db, 10, 20, 25);

    // Test 6: re-run without reloading
    db = dump_log.size(); rb = run_cnt;
    run_prog(0, 1'b0, 1'b1, st);
    chk("t6_done", done, 1);
    chk("t6_cycles_same", cycles, cyc1);
    chk("t6_run_cycles_same", run_cnt - rb, rb1);
    chk_dump(db, 10, 20, 25);

    // Randomized: random operands, stray high-memory writes, random ready, host noise
    for (int it = 0; it < 3; it++) begin
      ra  = 16'($urandom_range(0, 16'h3fff));
      rbv = 16'($urandom_range(0, 16'h3fff));
      rc  = 16'($urandom_range(0, 16'h3fff));
      for (int j = 0; j < 3; j++) vecs.push_back('{ADDR_W'($urandom_range(512, 1023)), $urandom});
      set_prog(ra, rbv, rc);
      load_vecs();
      db = dump_log.size(); sb = stab_err;
      run_prog(2, 1'b1, 1'b1, st);
      chk($sformatf("rnd%0d_done", it), done, 1);
      chk($sformatf("rnd%0d_stable", it), stab_err - sb, 0);
      chk_dump(db, {16'd0, ra}, {16'd0, rbv}, {16'd0, rc});
    end
    chk("rnd_no_ready_busy", rdy_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Host-facing run controller for the pipelined MIPS32 core, on one clock. It loads a program into the core's instruction/data memory, initialises the core and lets it run. It monitors HALTED under a watchdog, then streams out the first DUMP_REGS architectural registers. It replaces hand-poking of Mem/Reg/PC/HALTED from benches and gives silicon-style bring-up.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, memory/register data width
DUMP_REGS, 6, registers streamed out after halt (R0..R(DUMP_REGS-1)), 1..32
TIMEOUT_CYC, 1024, max RUN cycles before watchdog abort
CNT_W, 16, cycle-counter width; TIMEOUT_CYC must be < 2^CNT_W

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  host load word valid
ld_ready  out  1  controller can accept load word
ld_addr  in  ADDR_W  load word address
ld_data  in  DATA_W  load word data
start  in  1  single-cycle run request
busy  out  1  in INIT/RUN/DUMP
done  out  1  run finished normally, dump complete
timeout  out  1  run aborted by watchdog
cycles  out  CNT_W  RUN cycles of last run
core_init  out  1  one-cycle pulse: core clears PC, HALTED, TAKEN_BRANCH
core_run  out  1  core clock-enable / pipeline advance
core_halted  in  1  core HALTED flag
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
rf_raddr  out  5  register-file debug read address (async read)
rf_rdata  in  DATA_W  register-file debug read data
dump_valid  out  1  dump word valid
dump_ready  in  1  host accepts dump word
dump_idx  out  5  register index of dump word
dump_data  out  DATA_W  register value

Behaviour:
- States: IDLE, INIT, RUN, DUMP, DONE, ERR. Reset -> IDLE.
- Reset values: all outputs 0, except ld_ready=1. cycles=0.
- Async reset mid-operation forces IDLE immediately: core_run=0 and dump_valid=0. A half-finished dump is discarded.
- Loading:
  - ld_ready=1 only in IDLE, DONE and ERR.
  - A transfer is ld_valid&&ld_ready.
  - On a transfer, mem_we/mem_addr/mem_wdata are registered and asserted the next cycle, for exactly one cycle.
  - No writes are issued in INIT/RUN/DUMP.
- start in IDLE/DONE/ERR -> INIT. It clears done, timeout and cycles. start is ignored in INIT/RUN/DUMP.
- start in the same cycle as a load transfer: both are honoured. The write lands during the INIT cycle, before RUN.
- INIT: exactly 1 cycle with core_init=1 and core_run=0, then -> RUN.
- RUN:
  - core_run=1 and cycles increments by 1 every RUN cycle, saturating.
  - If core_halted is sampled 1: -> DUMP, core_run=0 from the next cycle, cycles frozen.
  - If cycles==TIMEOUT_CYC-1 without halt: -> ERR, timeout=1, core_run=0.
  - Halt and timeout in the same cycle: halt wins.
- DUMP:
  - Index counter starts at 0.
  - rf_raddr=dump_idx=counter.
  - dump_data=rf_rdata combinationally.
  - dump_valid=1 for the whole state.
  - On dump_valid&&dump_ready the counter advances.
  - The transfer at index DUMP_REGS-1 -> DONE.
  - dump_valid stays high with stable idx/data while dump_ready=0.
- DONE: done=1 held until the next start. ERR: timeout=1 held until the next start.
- busy=1 exactly in INIT, RUN and DUMP.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (IDLE..ERR)
  - REG_IDX_W=5
  - default widths
  - HLT opcode constant 6'h3f, for benches
- One natural sub-module, mips_watchdog. It is the RUN cycle counter with clear, enable, saturate and terminal-count flag, and it drives cycles and the timeout condition.
- The FSM, load path and dump sequencer stay in mips_run_ctrl.

Test Plan:
1. Sum program, then start, with dump_ready=1:
   - Load 9 words: 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000.
   - Required: exactly 9 mem_we pulses at addresses 0..8.
   - Required: one core_init pulse, then core_run until halt.
   - Required dump: R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, then done=1 and busy=0.
2. Watchdog: TIMEOUT_CYC=64, program with no HLT -> timeout=1 after exactly 64 RUN cycles, done=0, no dump_valid, cycles=63.
3. Dump backpressure: dump_ready low for 3 cycles at each of idx 2 and 4 -> idx/data held stable, 6 transfers in order 0..5, no duplicates or skips.
4. Protocol guards:
   - ld_valid=1 and start pulses during RUN -> ld_ready=0, no mem_we, state unaffected.
   - start with a load transfer in the same cycle while in DONE -> write issued during the INIT cycle, then the run proceeds.
5. Reset mid-RUN and mid-DUMP (idx=3) -> all outputs at reset values immediately. A following load+start completes test 1 correctly.
6. Re-run from DONE without reloading -> done clears on start, same dump values as test 1, cycles equal to the first run's count.
